// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit computer: T-state counter, opcode/flag decode, halt state.
// Optional build macro EARLY_END_EN: instructions retire after their last non-zero microstep.
module microcode_sequencer #(
  parameter int unsigned NUM_STEPS = 5,
  parameter int unsigned STEP_W    = 3
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  int unsigned       w_step_i;
  logic [15:0]       w_ucode;
  logic              w_early_end;

  assign w_step_i = int'(r_step);

  // Microcode ROM; indexing by integer step keeps truncated (NUM_STEPS<5) builds free of aliased entries.
  always_comb begin
    w_ucode = '0;
    case (w_step_i)
      0: w_ucode = C_CO | C_MI;
      1: w_ucode = C_RO | C_II | C_CE;
      2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_ucode = C_IO | C_MI;
          OP_LDI: w_ucode = C_IO | C_AI;
          OP_JMP: w_ucode = C_IO | C_J;
          OP_JC:  w_ucode = carry_flag ? (C_IO | C_J) : '0;
          OP_JZ:  w_ucode = zero_flag  ? (C_IO | C_J) : '0;
          OP_OUT: w_ucode = C_AO | C_OI;
          OP_HLT: w_ucode = C_HLT;
          default: w_ucode = '0;
        endcase
      end
      3: begin
        case (opcode)
          OP_LDA: w_ucode = C_RO | C_AI;
          OP_ADD, OP_SUB: w_ucode = C_RO | C_BI;
          OP_STA: w_ucode = C_AO | C_RI;
          default: w_ucode = '0;
        endcase
      end
      4: begin
        case (opcode)
          OP_ADD: w_ucode = C_EO | C_AI | C_FI;
          OP_SUB: w_ucode = C_EO | C_AI | C_SU | C_FI;
          default: w_ucode = '0;
        endcase
      end
      default: w_ucode = '0;
    endcase
  end

`ifdef EARLY_END_EN
  int unsigned w_end_step;

  // JC/JZ end after T2 whether or not the jump is taken.
  always_comb begin
    w_end_step = 1;
    case (opcode)
      OP_LDA, OP_STA: w_end_step = 3;
      OP_ADD, OP_SUB: w_end_step = 4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: w_end_step = 2;
      OP_NOP: w_end_step = 1;
      default: w_end_step = 1;
    endcase
  end

  assign w_early_end = (w_step_i == w_end_step);
`else
  assign w_early_end = 1'b0;
`endif

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_RUN;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      ST_RUN: begin
        if (w_ucode[15]) begin
          w_state_nxt = ST_HALT;
        end else if ((r_step == LAST_STEP) || w_early_end) begin
          w_step_nxt = '0;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
        w_step_nxt  = r_step;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_step_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    ctrl   = '0;
    halted = 1'b0;
    step   = r_step;
    case (r_state)
      ST_RUN:  ctrl = w_ucode;
      ST_HALT: halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Control unit for the 8-bit computer. It holds the microstep (T-state) counter, decodes the 4-bit opcode from the instruction register together with the carry and zero flags, and drives the 16-bit control word that sequences the bus, registers, ALU, RAM and program counter. It also owns the halt state that freezes the machine.

Parameters:
NUM_STEPS, 5, microsteps per instruction (T0..T4); legal range 3..8
STEP_W, 3, width of step counter and step port; must satisfy 2^STEP_W >= NUM_STEPS

Ports:
clk  input  1  system clock; all state updates on rising edge
RESETn  input  1  asynchronous active-low reset
opcode  input  4  IR[7:4], valid from T2 onward
carry_flag  input  1  latched ALU carry from flags register
zero_flag  input  1  latched ALU zero from flags register
ctrl  output  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI
step  output  STEP_W  current microstep
halted  output  1  high while in HALT state

Behaviour:
- Reset (RESETn low, asynchronous): step=0, state=RUN, halted=0. ctrl = T0 fetch word (CO|MI), because ctrl is combinational from step.
- State: RUN and HALT.
- RUN: step increments each rising edge. Step NUM_STEPS-1 wraps to 0.
- RUN to HALT: on the rising edge where the ctrl HLT bit is 1. On that edge step holds its value.
- HALT: absorbing; only RESETn exits it. step frozen, halted=1, ctrl=0 (HLT bit included).
- ctrl is combinational from step, opcode, flags and state, with no added latency. Steps without an entry give ctrl=0.
- T0: CO MI. T1: RO II CE (the same for all opcodes).
- Per-opcode steps T2 / T3 / T4:
  - 0000 NOP: all 0.
  - 0001 LDA: IO MI / RO AI / 0.
  - 0010 ADD: IO MI / RO BI / EO AI FI.
  - 0011 SUB: IO MI / RO BI / EO AI SU FI.
  - 0100 STA: IO MI / AO RI / 0.
  - 0101 LDI: IO AI / 0 / 0.
  - 0110 JMP: IO J / 0 / 0.
  - 0111 JC: IO J if carry_flag, else 0.
  - 1000 JZ: IO J if zero_flag, else 0.
  - 1110 OUT: AO OI / 0 / 0.
  - 1111 HLT: HLT / 0 / 0.
  - 1001-1101 undefined: treated as NOP.
- Flags are sampled combinationally during T2. A flag change mid-step is reflected immediately.
- If NUM_STEPS is less than 5, steps at or beyond NUM_STEPS are never reached, so the microcode is truncated.
- Reset mid-instruction: immediate return to step 0 (fetch) in RUN. The opcode register is outside this block.

Optional Feature:
EARLY_END_EN:
- Defined: after the last non-zero microstep of an opcode, the counter wraps to 0 on the next edge.
- Last steps: LDA/ADD/SUB/STA end after T3/T4/T4/T3. LDI/JMP/JC/JZ/OUT end after T2. NOP and undefined opcodes end after T1. JC/JZ with flag false end after T2.
- Not defined: every instruction takes exactly NUM_STEPS cycles.
- The halt behaviour is identical in both builds.

Test Plan:
- Reset: hold RESETn=0 for 3 cycles, opcode=0101 -> step=0, halted=0, ctrl=0x4004. Release; next edge -> step=1, ctrl=0x1408.
- ADD sequence: opcode=0010 over steps 0..4 -> ctrl 0x4004, 0x1408, 0x4800, 0x1020, 0x0281. Then step wraps to 0.
- JC taken/not: opcode=0111 at T2 with carry_flag=1 -> ctrl=0x0802. With carry_flag=0 -> ctrl=0x0000. Repeat JZ with zero_flag.
- HLT: opcode=1111 reaches T2 -> ctrl=0x8000. Next edge -> halted=1, step stays 2, ctrl=0x0000 for 10 further cycles. RESETn pulse -> step=0, halted=0.
- Reset mid-operation: assert RESETn low asynchronously between edges at step 3 of LDA -> step=0 and ctrl=0x4004 before the next edge.
- EARLY_END_EN build: LDI -> step sequence 0,1,2,0. STA -> 0,1,2,3,0. Non-EARLY build: LDI -> 0,1,2,3,4,0.
